// File: rtl/cpu_defs_pkg.sv
// cpu_defs -- TLB entry layout, fetch-side TLB exception codes and buffer FSM states.
// rev 1.0
`default_nettype none
package cpu_defs;

    typedef struct packed {
        logic [18:0] VPN2;
        logic [7:0]  ASID;
        logic        G;
        logic [19:0] PFN0;
        logic [19:0] PFN1;
        logic [2:0]  C0;
        logic [2:0]  C1;
        logic        V0;
        logic        V1;
    } TLB_Entry;

    localparam logic [1:0] IF_TLBNone    = 2'b00;
    localparam logic [1:0] IF_TLBRefill  = 2'b01;
    localparam logic [1:0] IF_TLBInvalid = 2'b10;

    localparam logic [2:0] CACHED = 3'd3;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } itlb_state_t;

endpackage
`default_nettype wire

// File: rtl/itlb_cam.sv
// itlb_cam -- combinational ENTRY_NUM-way VPN2/ASID match over the buffered entries.
// rev 1.0
`default_nettype none
module itlb_cam
    import cpu_defs::*;
#(
    parameter int ENTRY_NUM = 4,
    parameter int PTR_W     = $clog2(ENTRY_NUM)
) (
    input  TLB_Entry [ENTRY_NUM-1:0] entries,
    input  logic [ENTRY_NUM-1:0]     valid,
    input  logic [18:0]              vpn2,
    input  logic [7:0]               asid,
    output logic [ENTRY_NUM-1:0]     hit_vec,
    output logic [PTR_W-1:0]         hit_idx,
    output TLB_Entry                 hit_entry
);

    for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_match
        assign hit_vec[i] = valid[i] && (entries[i].VPN2 == vpn2)
                            && (entries[i].G || (entries[i].ASID == asid));
    end

    // Fill logic keeps hits one-hot, so an OR-style select is sufficient.
    always_comb begin
        hit_idx   = '0;
        hit_entry = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (hit_vec[i]) begin
                hit_idx   = PTR_W'(i);
                hit_entry = entries[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/itlb_multi_buffer.sv
// itlb_multi_buffer -- multi-entry PREIF translation buffer with main-TLB refill FSM.
// rev 1.0
`default_nettype none
module itlb_multi_buffer
    import cpu_defs::*;
#(
    parameter int ENTRY_NUM = 4,
    parameter int PTR_W     = $clog2(ENTRY_NUM)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        I_Req,
    input  logic [31:0] Virt_Iaddr,
    input  logic [7:0]  Cur_ASID,
    input  logic        K0_Cached,
    input  logic        TLBBuffer_Flush,
    input  logic        s0_found,
    input  TLB_Entry    I_TLBEntry,
    output logic        I_TLBReq,
    output logic [31:13] I_VPN2,
    output logic [31:0] Phsy_Iaddr,
    output logic        I_IsCached,
    output logic        I_IsTLBBufferValid,
    output logic        I_IsTLBStall,
    output logic [1:0]  IF_TLBExceptType
);

    TLB_Entry [ENTRY_NUM-1:0] entries;
    logic [ENTRY_NUM-1:0]     valid;
    logic [PTR_W-1:0]         ptr;
    logic [PTR_W-1:0]         victim;
    logic                     pend_valid;
    logic [18:0]              pend_vpn2;
    logic [18:0]              req_vpn2;
    itlb_state_t              state;

    logic [ENTRY_NUM-1:0]     hit_vec;
    logic [PTR_W-1:0]         unused_hit_idx;
    TLB_Entry                 hit_entry;
    logic                     hit;
    logic                     unmapped;
    logic                     pend_hit;
    logic                     miss_start;
    logic [19:0]              page_pfn;
    logic [2:0]               page_c;
    logic                     page_v;

    itlb_cam #(
        .ENTRY_NUM (ENTRY_NUM),
        .PTR_W     (PTR_W)
    ) u_cam (
        .entries   (entries),
        .valid     (valid),
        .vpn2      (Virt_Iaddr[31:13]),
        .asid      (Cur_ASID),
        .hit_vec   (hit_vec),
        .hit_idx   (unused_hit_idx),
        .hit_entry (hit_entry)
    );

    assign hit      = |hit_vec;
    assign unmapped = (Virt_Iaddr[31:30] == 2'b10);
    assign pend_hit = pend_valid && (pend_vpn2 == Virt_Iaddr[31:13]);
    assign page_pfn = Virt_Iaddr[12] ? hit_entry.PFN1 : hit_entry.PFN0;
    assign page_c   = Virt_Iaddr[12] ? hit_entry.C1   : hit_entry.C0;
    assign page_v   = Virt_Iaddr[12] ? hit_entry.V1   : hit_entry.V0;

    assign I_TLBReq = (state == S_REQ);
    assign I_VPN2   = req_vpn2;

    always_comb begin
        victim = ptr;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (!valid[i]) victim = PTR_W'(i);
        end
    end

    always_comb begin
        Phsy_Iaddr         = '0;
        I_IsCached         = 1'b0;
        I_IsTLBBufferValid = 1'b0;
        I_IsTLBStall       = 1'b0;
        IF_TLBExceptType   = IF_TLBNone;
        miss_start         = 1'b0;
        if (state == S_REQ) begin
            I_IsTLBStall = 1'b1;
        end else if (I_Req) begin
            if (unmapped) begin
                I_IsTLBBufferValid = 1'b1;
                Phsy_Iaddr         = {3'b000, Virt_Iaddr[28:0]};
                I_IsCached         = !Virt_Iaddr[29] && K0_Cached;
            end else if (hit) begin
                I_IsTLBBufferValid = 1'b1;
                Phsy_Iaddr         = {page_pfn, Virt_Iaddr[11:0]};
                I_IsCached         = (page_c == CACHED);
                if (!page_v) IF_TLBExceptType = IF_TLBInvalid;
            end else if (pend_hit) begin
                I_IsTLBBufferValid = 1'b1;
                IF_TLBExceptType   = IF_TLBRefill;
            end else begin
                I_IsTLBStall = 1'b1;
                miss_start   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            valid      <= '0;
            ptr        <= '0;
            pend_valid <= 1'b0;
            pend_vpn2  <= '0;
            req_vpn2   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss_start) begin
                        req_vpn2 <= Virt_Iaddr[31:13];
                        state    <= S_REQ;
                    end
                end
                S_REQ: begin
                    state <= S_IDLE;
                    if (!TLBBuffer_Flush) begin
                        if (s0_found) begin
                            entries[victim] <= I_TLBEntry;
                            valid[victim]   <= 1'b1;
                            ptr             <= ptr + PTR_W'(1);
                            pend_valid      <= 1'b0;
                        end else begin
                            pend_valid <= 1'b1;
                            pend_vpn2  <= req_vpn2;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
            // Flush wins over any fill or pending update made above.
            if (TLBBuffer_Flush) begin
                valid      <= '0;
                pend_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/itlb_multi_buffer.md
# itlb_multi_buffer

Parametrised instruction-side translation buffer in the PREIF stage, successor to the single-entry ITLB buffer. It holds ENTRY_NUM cached TLB entries and translates the PREIF PC combinationally on a hit. On a miss it stalls fetch, queries the main TLB through a one-cycle refill handshake, and fills a victim slot. It reports refill and invalid exceptions to PREIF, and handles unmapped kseg0/kseg1 addresses directly.

## Interface
Parameters:
- ENTRY_NUM, 4: number of buffered entries; power of two, 2 to 16.
- PTR_W, $clog2(ENTRY_NUM): width of the victim pointer.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- I_Req  in  1  fetch lookup active this cycle.
- Virt_Iaddr  in  32  PREIF PC.
- Cur_ASID  in  8  CP0 EntryHi.ASID.
- K0_Cached  in  1  Config.K0 says kseg0 is cacheable.
- TLBBuffer_Flush  in  1  invalidate all entries. Asserted on TLBWR/TLBWI/EntryHi write.
- s0_found  in  1  main TLB hit for I_VPN2; valid in the same cycle as I_TLBReq.
- I_TLBEntry  in  TLB_Entry  matching main-TLB entry. Fields: VPN2, ASID, G, PFN0/1, C0/1, V0/1.
- I_TLBReq  out  1  refill probe is valid this cycle.
- I_VPN2  out  [31:13]  VPN2 being probed.
- Phsy_Iaddr  out  32  translated address.
- I_IsCached  out  1  translated page is cacheable.
- I_IsTLBBufferValid  out  1  translation or exception result is valid this cycle.
- I_IsTLBStall  out  1  PREIF must hold its PC.
- IF_TLBExceptType  out  2  exception code: IF_TLBNone=00, IF_TLBRefill=01, IF_TLBInvalid=10.

## Operation
- Unmapped addresses:
  - Virt_Iaddr[31:30]==2'b10 selects kseg0/kseg1. Phsy_Iaddr = {3'b0, Virt_Iaddr[28:0]}.
  - I_IsCached = K0_Cached for kseg0 and 0 for kseg1.
  - These addresses never stall and never raise an exception.
- Hit condition for entry i: valid[i], VPN2 equal to Virt_Iaddr[31:13], and (G or ASID==Cur_ASID). At most one entry hits; fill logic guarantees this.
- Page select: Virt_Iaddr[12] picks the odd or even half. Phsy_Iaddr = {PFN[19:0], Virt_Iaddr[11:0]}. I_IsCached = (C==3'd3).
- On a hit with V=0: IF_TLBExceptType=IF_TLBInvalid, no stall, I_IsTLBBufferValid=1.
- FSM states:
  - IDLE: a mapped miss with I_Req=1 and no matching pending-refill record sets I_IsTLBStall=1, latches the VPN2, and moves to REQ.
  - REQ: drives I_TLBReq=1 and I_VPN2 from the latched value; stall stays 1.
    - If s0_found: write I_TLBEntry into the victim slot, set it valid, advance the pointer.
    - If not found: set pend_valid and pend_vpn2 = latched VPN2.
    - Either way, return to IDLE.
- Pending refill: in IDLE, a mapped miss whose VPN2 equals pend_vpn2 with pend_valid set gives IF_TLBRefill, no stall, I_IsTLBBufferValid=1. pend_valid clears on flush or on any successful fill.
- Victim selection: the lowest-index invalid entry if one exists; otherwise the round-robin pointer, which wraps ENTRY_NUM-1 to 0.
- Flush:
  - Clears all valid bits and pend_valid.
  - In REQ it aborts the fill (no write) and returns to IDLE.
  - Flush has priority over a same-cycle fill.
- When I_Req=0: no FSM transition out of IDLE, I_IsTLBStall=0, I_IsTLBBufferValid=0.

## Timing
- Reset (resetn=0 at a posedge): state=IDLE, all valid=0, pointer=0, pend_valid=0, latched VPN2=0. A reset asserted while in REQ returns to IDLE with no write.
- Outputs after reset: I_TLBReq=0, I_IsTLBStall=0, I_IsTLBBufferValid=0, IF_TLBExceptType=00, Phsy_Iaddr=0, I_IsCached=0, I_VPN2=0.
- Hit or unmapped: zero-latency combinational result, no stall.
- Miss with main-TLB hit: stall for exactly 2 cycles (miss cycle, then REQ); valid translation on the 3rd cycle.
- Miss with main-TLB miss: 2 stall cycles, then IF_TLBRefill on the 3rd cycle.
- Virt_Iaddr must stay stable while I_IsTLBStall=1. If it changes, the REQ still completes and the new address is looked up in IDLE.

## Structure
- Shared package cpu_defs holds the TLB_Entry typedef, the IF_TLBNone/IF_TLBRefill/IF_TLBInvalid encodings, and the cache attribute constant CACHED=3'd3.
- One natural sub-module: itlb_cam. It is a combinational ENTRY_NUM-way match that outputs a one-hot hit vector, the hit index, and the selected entry. The FSM, victim pointer and pending record stay in the top.

## Test plan
- Kseg1 address 0xBFC0_0000, I_Req=1 -> Phsy_Iaddr 0x1FC0_0000, I_IsCached=0, no stall, exception 00.
- Mapped 0x0040_1000 cold, main TLB returns VPN2 0x00200, PFN1 0x12345, V1=1, C1=3 -> stall 2 cycles with I_TLBReq=1 in cycle 2; cycle 3 gives Phsy_Iaddr 0x1234_5000, I_IsCached=1.
- Main TLB returns s0_found=0 for 0x0080_0000 -> 2 stall cycles, then IF_TLBRefill held with no stall until flush.
- Fill 5 distinct VPN2s with ENTRY_NUM=4 -> the 5th fill overwrites entry 0; the first VPN2 then misses again.
- Hit entry with V0=0 at 0x0040_0000 -> IF_TLBInvalid, no stall. Change Cur_ASID on a non-global entry -> miss.
- TLBBuffer_Flush in the REQ cycle with s0_found=1 -> no entry written, state IDLE, the next lookup misses.
